// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the bus-based CPU datapath: data width, opcode
// width, ALU opcode encodings and the IR immediate sign-extension helper.
package cpu_datapath_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01100;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01101;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b01111;

  // The C bus source is the 19-bit IR immediate, sign-extended.
  function automatic logic [DATA_W-1:0] sext19(input logic [18:0] imm);
    return {{13{imm[18]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Control/data bundle between an external control unit (master) and the
// datapath (slave): one-hot bus selects, load enables, opcode and data.
interface cpu_datapath_if;
  import cpu_datapath_pkg::*;

  logic [15:0]       r_in;
  logic [15:0]       r_out;
  logic              pc_in, ir_in, hi_in, lo_in, zhigh_in, zlow_in;
  logic              mar_in, mdr_in, outport_in, c_in, y_in;
  logic              pc_out, hi_out, lo_out, zhigh_out, zlow_out;
  logic              mdr_out, inport_out, c_out;
  logic              read;
  logic              inc_pc;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] mdatain;
  logic [DATA_W-1:0] inport_data;
  logic [DATA_W-1:0] bus_mux_out;
  logic [DATA_W-1:0] outport_data;

  modport master (
    output r_in, r_out, pc_in, ir_in, hi_in, lo_in, zhigh_in, zlow_in,
           mar_in, mdr_in, outport_in, c_in, y_in, pc_out, hi_out, lo_out,
           zhigh_out, zlow_out, mdr_out, inport_out, c_out, read, inc_pc,
           op, mdatain, inport_data,
    input  bus_mux_out, outport_data
  );

  modport slave (
    input  r_in, r_out, pc_in, ir_in, hi_in, lo_in, zhigh_in, zlow_in,
           mar_in, mdr_in, outport_in, c_in, y_in, pc_out, hi_out, lo_out,
           zhigh_out, zlow_out, mdr_out, inport_out, c_out, read, inc_pc,
           op, mdatain, inport_data,
    output bus_mux_out, outport_data
  );

endinterface

// File: rtl/cpu_datapath_reg32.sv
// 32-bit register with load enable and asynchronous active-low clear.
module cpu_datapath_reg32
  import cpu_datapath_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  assign q_d = en_i ? d_i : q_q;

  // Hold or load on the rising edge; clear is immediate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 32'h0000_0000;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cpu_datapath.sv
// Bus-based 32-bit CPU datapath: register file, special registers, a single
// shared bus with fixed-priority source select, and a combinational ALU that
// feeds the 64-bit Z register. All sequencing is external.
module cpu_datapath
  import cpu_datapath_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  cpu_datapath_if.slave  bus_if
);

  logic [DATA_W-1:0] r_q [16];
  logic [DATA_W-1:0] pc_q, ir_q, hi_q, lo_q, y_q, mar_q, mdr_q, outport_q;
  logic [DATA_W-1:0] zhigh_q, zlow_q;
  logic [DATA_W-1:0] bus_s, mdr_d, c_s;
  logic [63:0]       alu_s;

  // General registers R0..R15.
  for (genvar gi = 0; gi < 16; gi++) begin : g_gpr
    cpu_datapath_reg32 u_r (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.r_in[gi]),
                            .d_i(bus_s), .q_o(r_q[gi]));
  end

  assign mdr_d = bus_if.read ? bus_if.mdatain : bus_s;

  cpu_datapath_reg32 u_pc  (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.pc_in),      .d_i(bus_s),         .q_o(pc_q));
  cpu_datapath_reg32 u_ir  (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.ir_in),      .d_i(bus_s),         .q_o(ir_q));
  cpu_datapath_reg32 u_hi  (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.hi_in),      .d_i(bus_s),         .q_o(hi_q));
  cpu_datapath_reg32 u_lo  (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.lo_in),      .d_i(bus_s),         .q_o(lo_q));
  cpu_datapath_reg32 u_y   (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.y_in),       .d_i(bus_s),         .q_o(y_q));
  cpu_datapath_reg32 u_mar (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.mar_in),     .d_i(bus_s),         .q_o(mar_q));
  cpu_datapath_reg32 u_mdr (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.mdr_in),     .d_i(mdr_d),         .q_o(mdr_q));
  cpu_datapath_reg32 u_out (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.outport_in), .d_i(bus_s),         .q_o(outport_q));
  cpu_datapath_reg32 u_zh  (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.zhigh_in),   .d_i(alu_s[63:32]),  .q_o(zhigh_q));
  cpu_datapath_reg32 u_zl  (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(bus_if.zlow_in),    .d_i(alu_s[31:0]),   .q_o(zlow_q));

  assign c_s = sext19(ir_q[18:0]);

  // Bus source mux: later assignments override earlier ones, so the list
  // runs from lowest priority (C) up to highest (R0).
  always_comb begin
    bus_s = 32'h0000_0000;
    if (bus_if.c_out)      bus_s = c_s;        else bus_s = bus_s;
    if (bus_if.inport_out) bus_s = bus_if.inport_data; else bus_s = bus_s;
    if (bus_if.mdr_out)    bus_s = mdr_q;      else bus_s = bus_s;
    if (bus_if.pc_out)     bus_s = pc_q;       else bus_s = bus_s;
    if (bus_if.zlow_out)   bus_s = zlow_q;     else bus_s = bus_s;
    if (bus_if.zhigh_out)  bus_s = zhigh_q;    else bus_s = bus_s;
    if (bus_if.lo_out)     bus_s = lo_q;       else bus_s = bus_s;
    if (bus_if.hi_out)     bus_s = hi_q;       else bus_s = bus_s;
    for (int i = 15; i >= 0; i--) begin
      if (bus_if.r_out[i]) bus_s = r_q[i];     else bus_s = bus_s;
    end
  end

  logic [DATA_W-1:0]        a_s, b_s;
  logic [4:0]               sh_s;
  logic [63:0]              a_ext_s, b_ext_s, prod_s;
  logic signed [DATA_W-1:0] a_sg_s, b_sg_s, quot_s, rem_s;

  assign a_s     = y_q;
  assign b_s     = bus_s;
  assign sh_s    = b_s[4:0];
  assign a_sg_s  = a_s;
  assign b_sg_s  = b_s;
  assign a_ext_s = {{32{a_s[31]}}, a_s};
  assign b_ext_s = {{32{b_s[31]}}, b_s};
  assign prod_s  = a_ext_s * b_ext_s;

  // Signed divide; a zero divisor yields a zero quotient and remainder.
  always_comb begin
    quot_s = 32'sd0;
    rem_s  = 32'sd0;
    if (b_s != 32'h0000_0000) begin
      quot_s = a_sg_s / b_sg_s;
      rem_s  = a_sg_s % b_sg_s;
    end else begin
      quot_s = 32'sd0;
      rem_s  = 32'sd0;
    end
  end

  // ALU: A = Y, B = bus; IncPC overrides the opcode with B+1.
  always_comb begin
    alu_s = 64'h0;
    if (bus_if.inc_pc) begin
      alu_s = {32'h0000_0000, b_s + 32'd1};
    end else begin
      case (bus_if.op)
        OP_ADD:  alu_s = {32'h0000_0000, a_s + b_s};
        OP_SUB:  alu_s = {32'h0000_0000, a_s - b_s};
        OP_AND:  alu_s = {32'h0000_0000, a_s & b_s};
        OP_OR:   alu_s = {32'h0000_0000, a_s | b_s};
        OP_SHR:  alu_s = {32'h0000_0000, a_s >> sh_s};
        OP_SHL:  alu_s = {32'h0000_0000, a_s << sh_s};
        OP_SHRA: alu_s = {32'h0000_0000, a_sg_s >>> sh_s};
        OP_ROR:  alu_s = {32'h0000_0000, (a_s >> sh_s) | (a_s << (6'd32 - {1'b0, sh_s}))};
        OP_ROL:  alu_s = {32'h0000_0000, (a_s << sh_s) | (a_s >> (6'd32 - {1'b0, sh_s}))};
        OP_MUL:  alu_s = prod_s;
        OP_DIV:  alu_s = {rem_s, quot_s};
        OP_NEG:  alu_s = {32'h0000_0000, 32'h0000_0000 - b_s};
        OP_NOT:  alu_s = {32'h0000_0000, ~b_s};
        default: alu_s = 64'h0;
      endcase
    end
  end

  assign bus_if.bus_mux_out  = bus_s;
  assign bus_if.outport_data = outport_q;

  // MAR has no reader inside this block, Cin is reserved and only the low
  // IR bits form the immediate; fold them together so they stay visible.
  logic unused_s;
  assign unused_s = ^{mar_q, ir_q[31:19], bus_if.c_in};

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed test of cpu_datapath: register transfers, fetch sequence, ALU
// opcodes, bus priority, async clear, against hand-computed values.
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  cpu_datapath_if bus_if ();

  cpu_datapath dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_if (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic ctl_idle();
    bus_if.r_in = 16'h0000;      bus_if.r_out = 16'h0000;
    bus_if.pc_in = 1'b0;         bus_if.ir_in = 1'b0;      bus_if.hi_in = 1'b0;
    bus_if.lo_in = 1'b0;         bus_if.zhigh_in = 1'b0;   bus_if.zlow_in = 1'b0;
    bus_if.mar_in = 1'b0;        bus_if.mdr_in = 1'b0;     bus_if.outport_in = 1'b0;
    bus_if.c_in = 1'b0;          bus_if.y_in = 1'b0;       bus_if.pc_out = 1'b0;
    bus_if.hi_out = 1'b0;        bus_if.lo_out = 1'b0;     bus_if.zhigh_out = 1'b0;
    bus_if.zlow_out = 1'b0;      bus_if.mdr_out = 1'b0;    bus_if.inport_out = 1'b0;
    bus_if.c_out = 1'b0;         bus_if.read = 1'b0;       bus_if.inc_pc = 1'b0;
    bus_if.op = 5'b00000;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    ctl_idle();
  endtask

  task automatic rd_bus(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, bus_if.bus_mux_out, exp);
    ctl_idle();
  endtask

  task automatic rd_r(input string tag, input int idx, input logic [31:0] exp);
    bus_if.r_out[idx] = 1'b1;
    rd_bus(tag, exp);
  endtask

  task automatic load_r(input int idx, input logic [31:0] v);
    bus_if.mdatain = v; bus_if.read = 1'b1; bus_if.mdr_in = 1'b1;
    tick();
    bus_if.mdr_out = 1'b1; bus_if.r_in[idx] = 1'b1;
    tick();
  endtask

  task automatic alu(input int ra, input int rb, input logic [4:0] opc);
    bus_if.r_out[ra] = 1'b1; bus_if.y_in = 1'b1;
    tick();
    bus_if.r_out[rb] = 1'b1; bus_if.op = opc;
    bus_if.zhigh_in = 1'b1; bus_if.zlow_in = 1'b1;
    tick();
  endtask

  task automatic chk_z(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    bus_if.zhigh_out = 1'b1;
    rd_bus({tag, ".zhigh"}, hi);
    bus_if.zlow_out = 1'b1;
    rd_bus({tag, ".zlow"}, lo);
  endtask

  initial begin
    rst_ni = 1'b0;
    bus_if.mdatain = 32'h0;
    bus_if.inport_data = 32'h0;
    ctl_idle();
    #12;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset state
    rd_bus("rst.idle_bus", 32'h0);
    chk("rst.outport", bus_if.outport_data, 32'h0);
    rd_r("rst.r3", 3, 32'h0);
    bus_if.pc_out = 1'b1; rd_bus("rst.pc", 32'h0);

    // Register loads through MDR
    load_r(3, 32'h12); rd_r("load.r3", 3, 32'h12);
    load_r(5, 32'h14); rd_r("load.r5", 5, 32'h14);
    load_r(1, 32'h18); rd_r("load.r1", 1, 32'h18);

    // Bus priority and idle
    bus_if.r_out[1] = 1'b1; bus_if.r_out[5] = 1'b1; rd_bus("prio.r1_r5", 32'h18);
    bus_if.r_out[5] = 1'b1; bus_if.pc_out = 1'b1;   rd_bus("prio.r5_pc", 32'h14);
    rd_bus("prio.idle", 32'h0);

    // Basic ALU ops with R3=0x12, R5=0x14
    alu(3, 5, OP_ADD);   chk_z("add", 32'h0, 32'h26);
    alu(5, 3, OP_SUB);   chk_z("sub_pos", 32'h0, 32'h2);
    alu(3, 5, OP_SUB);   chk_z("sub_wrap", 32'h0, 32'hFFFF_FFFE);
    alu(3, 5, OP_AND);   chk_z("and", 32'h0, 32'h10);
    alu(3, 5, OP_OR);    chk_z("or", 32'h0, 32'h16);
    alu(3, 5, OP_NEG);   chk_z("neg", 32'h0, 32'hFFFF_FFEC);
    alu(3, 5, OP_NOT);   chk_z("not", 32'h0, 32'hFFFF_FFEB);
    alu(3, 5, 5'b00000); chk_z("bad_op", 32'h0, 32'h0);

    // Fetch sequence
    bus_if.pc_out = 1'b1; bus_if.inc_pc = 1'b1; bus_if.op = OP_MUL;
    bus_if.zlow_in = 1'b1; bus_if.zhigh_in = 1'b1;
    tick();
    chk_z("incpc", 32'h0, 32'h1);
    bus_if.zlow_out = 1'b1; bus_if.pc_in = 1'b1; tick();
    bus_if.pc_out = 1'b1; rd_bus("fetch.pc", 32'h1);
    bus_if.mdatain = 32'h409A_8000; bus_if.read = 1'b1; bus_if.mdr_in = 1'b1; tick();
    bus_if.mdr_out = 1'b1; bus_if.ir_in = 1'b1; tick();
    bus_if.c_out = 1'b1; rd_bus("fetch.c", 32'h0002_8000);

    // Output and input ports
    bus_if.r_out[1] = 1'b1; bus_if.outport_in = 1'b1; tick();
    chk("outport", bus_if.outport_data, 32'h18);
    bus_if.inport_data = 32'hCAFE_BABE; bus_if.inport_out = 1'b1;
    rd_bus("inport", 32'hCAFE_BABE);

    // Shifts and rotates: R3=0x80000010, R5=4, R7=0x20 (amount 0), R1=0x18
    load_r(3, 32'h8000_0010); load_r(5, 32'h4); load_r(7, 32'h20);
    alu(3, 5, OP_SHRA); chk_z("shra", 32'h0, 32'hF800_0001);
    alu(3, 5, OP_SHR);  chk_z("shr", 32'h0, 32'h0800_0001);
    alu(3, 5, OP_SHL);  chk_z("shl", 32'h0, 32'h0000_0100);
    alu(3, 5, OP_ROL);  chk_z("rol", 32'h0, 32'h0000_0108);
    alu(3, 1, OP_ROR);  chk_z("ror24", 32'h0, 32'h0000_1080);
    alu(3, 7, OP_SHL);  chk_z("shl0", 32'h0, 32'h8000_0010);
    alu(3, 7, OP_ROR);  chk_z("ror0", 32'h0, 32'h8000_0010);

    // Multiply, then a ZLow-only load leaves ZHigh untouched
    load_r(3, 32'hFFFF_FFFF); load_r(5, 32'h2);
    alu(3, 5, OP_MUL); chk_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    bus_if.r_out[3] = 1'b1; bus_if.y_in = 1'b1; tick();
    bus_if.r_out[5] = 1'b1; bus_if.op = OP_ADD; bus_if.zlow_in = 1'b1; tick();
    chk_z("zlow_only", 32'hFFFF_FFFF, 32'h1);

    // Divide
    load_r(3, 32'h7);
    alu(3, 5, OP_DIV); chk_z("div", 32'h1, 32'h3);
    load_r(3, 32'hFFFF_FFF9);
    alu(3, 5, OP_DIV); chk_z("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    alu(3, 0, OP_DIV); chk_z("div0", 32'h0, 32'h0);

    // Async clear between edges, with a load attempted while held low
    load_r(1, 32'h18);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("clr.outport", bus_if.outport_data, 32'h0);
    rd_r("clr.r1", 1, 32'h0);
    rd_r("clr.r3", 3, 32'h0);
    bus_if.pc_out = 1'b1;  rd_bus("clr.pc", 32'h0);
    bus_if.c_out = 1'b1;   rd_bus("clr.ir_c", 32'h0);
    rd_bus("clr.idle", 32'h0);
    bus_if.mdatain = 32'h55; bus_if.read = 1'b1; bus_if.mdr_in = 1'b1;
    @(posedge clk_i);
    #1;
    bus_if.mdr_out = 1'b1; rd_bus("clr.mdr_held", 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ctl_idle();
    #1;
    rd_r("clr.r1_after", 1, 32'h0);
    load_r(1, 32'h55); rd_r("clr.reload", 1, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
